// File: rtl/cdc_2phase_rx_fifo_serv.sv
// cdc_2phase_rx_fifo_serv: 2-phase req/ack receiver feeding a DEPTH-entry FIFO with a valid/ready drain.
// Define CDC_2PHASE_RX_FIFO_CNT_EN to enable the 32-bit capture counter on rx_count_o.
module cdc_2phase_rx_fifo_serv #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       async_req_i,
    input  logic [DATA_WIDTH-1:0]      async_data_i,
    output logic                       async_ack_o,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [31:0]                rx_count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_q;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  last_q;
    logic                   push;
    logic                   pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Full is judged on the pre-edge level, so a same-edge pop never frees a slot for capture.
    assign push        = (sync_q[SYNC_STAGES-1] ^ ack_q) && (level != LW'(DEPTH));
    assign valid_o     = level != '0;
    assign pop         = valid_o && ready_i;
    assign data_o      = valid_o ? mem[rd_ptr] : last_q;
    assign async_ack_o = ack_q;
    assign level_o     = level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            ack_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_req_i};
            if (push) begin
                mem[wr_ptr] <= async_data_i;
                wr_ptr      <= inc(wr_ptr);
                ack_q       <= ~ack_q;
            end
            if (pop) begin
                rd_ptr <= inc(rd_ptr);
                last_q <= mem[rd_ptr];
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

`ifdef CDC_2PHASE_RX_FIFO_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (push) cnt_q <= cnt_q + 32'd1;
    end
    assign rx_count_o = cnt_q;
`else
    assign rx_count_o = '0;
`endif
endmodule

// File: tb/tb_cdc_2phase_rx_fifo_serv.sv
// tb_cdc_2phase_rx_fifo_serv: directed checks of capture latency, fill/backpressure, same-edge push+pop, wrap, reset and counter.
module tb_cdc_2phase_rx_fifo_serv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, ready_a, ack_a, valid_a;
    logic [7:0]  data_a, dout_a;
    logic [2:0]  level_a;
    logic [31:0] cnt_a;
    logic        req_b, ready_b, ack_b, valid_b;
    logic [7:0]  data_b, dout_b;
    logic [1:0]  level_b;
    logic [31:0] cnt_b;
    int checks = 0;
    int passed = 0;
    int k, n, maxl;

    always #5 clk = ~clk;

    cdc_2phase_rx_fifo_serv #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .async_req_i(req_a), .async_data_i(data_a),
        .async_ack_o(ack_a), .data_o(dout_a), .valid_o(valid_a), .ready_i(ready_a),
        .level_o(level_a), .rx_count_o(cnt_a));

    cdc_2phase_rx_fifo_serv #(.DATA_WIDTH(8), .DEPTH(3), .SYNC_STAGES(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .async_req_i(req_b), .async_data_i(data_b),
        .async_ack_o(ack_b), .data_o(dout_b), .valid_o(valid_b), .ready_i(ready_b),
        .level_o(level_b), .rx_count_o(cnt_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_a(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        data_a = d;
        req_a  = !req_a;
        while (ack_a !== req_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (ack_a !== req_a) chk("ack_a_timeout", ack_a, req_a);
    endtask

    task automatic send_b(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        data_b = d;
        req_b  = !req_b;
        while (ack_b !== req_b && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (ack_b !== req_b) chk("ack_b_timeout", ack_b, req_b);
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 0; ready_a = 0; data_a = 0;
        req_b = 0; ready_b = 0; data_b = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_level", level_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_data", dout_a, 0);
        rst_n = 1'b1;

        // basic capture latency
        @(negedge clk);
        data_a = 8'hA5;
        req_a  = 1'b1;
        @(negedge clk);
        chk("lat_early_valid", valid_a, 0);
        chk("lat_early_ack", ack_a, 0);
        repeat (2) @(negedge clk);
        chk("lat_valid", valid_a, 1);
        chk("lat_data", dout_a, 8'hA5);
        chk("lat_ack", ack_a, 1);
        ready_a = 1;
        @(negedge clk);
        ready_a = 0;
        chk("pop_empty_valid", valid_a, 0);
        chk("hold_last_popped", dout_a, 8'hA5);

        // fill to full, fifth item held off
        for (int i = 1; i <= 4; i++) send_a(8'(i));
        chk("fill_level", level_a, 4);
        @(negedge clk);
        data_a = 8'h05;
        req_a  = !req_a;
        repeat (6) @(negedge clk);
        chk("full_ack_withheld", ack_a, !req_a);
        chk("full_level", level_a, 4);
        chk("hold_head", dout_a, 8'h01);
        ready_a = 1;
        k = 1;
        for (n = 0; n < 30 && k <= 5; n++) begin
            if (valid_a) begin
                chk("fill_order", dout_a, k);
                k++;
            end
            @(negedge clk);
        end
        ready_a = 0;
        chk("fill_count", k, 6);
        chk("fill_ack_done", ack_a, req_a);
        chk("fill_level_end", level_a, 0);

        // seventh capture for the counter
        send_a(8'h77);
        ready_a = 1;
        @(negedge clk);
        ready_a = 0;
`ifdef CDC_2PHASE_RX_FIFO_CNT_EN
        chk("rx_count", cnt_a, 7);
`else
        chk("rx_count", cnt_a, 0);
`endif

        // same-edge capture and pop on the DEPTH=3 instance
        send_b(8'h21); send_b(8'h22); send_b(8'h23);
        @(negedge clk);
        data_b = 8'h24;
        req_b  = !req_b;
        repeat (5) @(negedge clk);
        chk("b_full_level", level_b, 3);
        chk("b_full_ack", ack_b, !req_b);
        ready_b = 1;
        @(negedge clk);
        chk("pop_no_capture_level", level_b, 2);
        chk("pop_no_capture_ack", ack_b, !req_b);
        @(negedge clk);
        ready_b = 0;
        chk("same_cycle_level", level_b, 2);
        chk("same_cycle_ack", ack_b, req_b);
        chk("same_cycle_head", dout_b, 8'h23);
        ready_b = 1;
        @(negedge clk);
        chk("same_cycle_next", dout_b, 8'h24);
        @(negedge clk);
        ready_b = 0;
        chk("same_cycle_drained", valid_b, 0);

        // wrap with random backpressure
        k = 0;
        maxl = 0;
        fork
            for (int i = 0; i < 10; i++) send_b(8'h10 + 8'(i));
            begin
                for (int c = 0; c < 600 && k < 10; c++) begin
                    @(negedge clk);
                    if (int'(level_b) > maxl) maxl = int'(level_b);
                    ready_b = 1'($urandom_range(0, 1));
                    if (valid_b && ready_b) begin
                        chk("wrap_order", dout_b, 8'h10 + 8'(k));
                        k++;
                    end
                end
                @(negedge clk);
                ready_b = 0;
            end
        join
        chk("wrap_count", k, 10);
        chk("wrap_max_level", maxl <= 3, 1);

        // reset in the middle of a stream
        send_a(8'h31); send_a(8'h32); send_a(8'h33);
        chk("pre_rst_level", level_a, 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_level", level_a, 0);
        chk("mid_rst_ack", ack_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);
        req_a = 0;
        req_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", valid_a, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
